alu_cmd_driver: RTL and testbench
=================================

// Module: alu_cmd_driver
// PURPOSE
//  Initiator side of the ALU BEGIN/END operation interface. Accepts one command
//  (op, X, Y, A_divide) on a valid/ready port and drives the ALU operands and BEGIN.
//  Waits for END, captures the 16-bit ALU result and returns it on a valid/ready
//  response port. Sits between the system controller and the ALU; one operation in flight.
// PARAMETERS
//  BEGIN_PULSE     1    cycles alu_begin held high per operation (>=1)
//  TIMEOUT_CYCLES  256  WAIT-state cycle limit; used only with ALU_TIMEOUT_EN
// PORTS
//  clk          in   1   single clock, all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   command accepted when cmd_valid & cmd_ready
//  cmd_op       in   2   ALU operation code (alu_pkg encoding)
//  cmd_x        in   8   operand X / multiplicand
//  cmd_y        in   8   operand Y / divisor
//  cmd_a_hi     in   8   dividend high byte (division only, else don't-care)
//  alu_x        out  8   to ALU X
//  alu_y        out  8   to ALU Y
//  alu_a_divide out  8   to ALU A_divide
//  alu_op       out  2   to ALU op
//  alu_begin    out  1   to ALU BEGIN
//  alu_end      in   1   from ALU END
//  alu_out      in   16  from ALU OUT
//  alu_flush    out  1   one-cycle request to reset the ALU (timeout only)
//  rsp_valid    out  1   result available
//  rsp_ready    in   1   result consumed when rsp_valid & rsp_ready
//  rsp_data     out  16  captured ALU result
//  rsp_op       out  2   op code of the result
//  rsp_timeout  out  1   result produced by timeout, rsp_data = 16'h0000
//  busy         out  1   state != IDLE
//  done_count   out  8   completed operations, wraps 255 -> 0
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, every output 0 except cmd_ready = 1.
//  - FSM IDLE -> ARM -> BEGIN -> WAIT -> RESP -> IDLE.
//  - IDLE: cmd_ready = 1; on handshake latch cmd_* into alu_x/alu_y/alu_a_divide/alu_op; -> ARM.
//  - ARM: stay while alu_end = 1 (stale END from previous op); when alu_end = 0 -> BEGIN.
//  - BEGIN: alu_begin = 1 for exactly BEGIN_PULSE cycles; alu_end ignored here; -> WAIT.
//  - WAIT: first cycle alu_end = 1: rsp_data <= alu_out, rsp_op <= alu_op, rsp_valid <= 1,
//    rsp_timeout <= 0, done_count++; -> RESP.
//  - RESP: rsp_valid/rsp_data/rsp_op held stable until rsp_ready; on handshake rsp_valid <= 0, -> IDLE.
//  - cmd_ready = 0 in every state but IDLE; no command accepted in the response handshake cycle.
//  - alu_x/alu_y/alu_a_divide/alu_op held stable from latch until the next accepted command.
//  - Latency, ALU END low at accept: accept edge t, alu_begin high t+2..t+1+BEGIN_PULSE,
//    rsp_valid high the cycle after alu_end is sampled high in WAIT.
//  - Reset mid-operation: IDLE on the next edge, alu_begin drops, pending result discarded;
//    a later alu_end in IDLE is ignored.
// CONFIGURATION
//  ALU_TIMEOUT_EN defined: 16-bit counter clears on entry to WAIT, increments in WAIT;
//   at TIMEOUT_CYCLES without alu_end: rsp_valid <= 1, rsp_timeout <= 1, rsp_data <= 0,
//   alu_flush = 1 for one cycle, -> RESP; done_count not incremented. Late alu_end ignored.
//  ALU_TIMEOUT_EN undefined: no counter, WAIT unbounded, rsp_timeout and alu_flush tied 0.
// STRUCTURE
//  alu_pkg: ALU op codes (ADD 2'b00, SUB 2'b01, MUL 2'b10, DIV 2'b11), FSM state enum,
//   operand/result widths.
//  Sub-module alu_watchdog (counter + compare), instantiated only under ALU_TIMEOUT_EN.
// TESTING
//  1 Reset asserted 3 cycles -> all outputs 0, cmd_ready = 1, busy = 0.
//  2 MUL x=7 y=6, ALU model END 10 cycles after BEGIN with OUT=16'h002A -> one-cycle
//    alu_begin at t+2, rsp_valid with rsp_data=16'h002A, rsp_op=2'b10, done_count=1.
//  3 rsp_ready low 5 cycles after result -> rsp_valid/rsp_data stable, cmd_ready = 0, second
//    cmd_valid not accepted until response handshake.
//  4 alu_end held high at accept for 4 cycles -> alu_begin withheld until alu_end low, then pulses.
//  5 ALU_TIMEOUT_EN, TIMEOUT_CYCLES=64, END never -> rsp_timeout=1, rsp_data=0, alu_flush
//    1 cycle after 64 WAIT cycles; macro off -> no rsp_valid within 1000 cycles.
//  6 reset during WAIT, then alu_end pulse -> state IDLE, alu_begin 0, rsp_valid stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: op codes, FSM states, widths.
package alu_pkg;

   localparam int OPERAND_W = 8;
   localparam int RESULT_W  = 16;
   localparam int COUNT_W   = 8;
   localparam int WDOG_W    = 16;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_BEGIN = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command, ALU-side and response signals of alu_cmd_driver.
// master = the driver itself, slave = controller/ALU side.
interface alu_cmd_driver_if;
   import alu_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   alu_op_e              cmd_op;
   logic [OPERAND_W-1:0] cmd_x;
   logic [OPERAND_W-1:0] cmd_y;
   logic [OPERAND_W-1:0] cmd_a_hi;

   logic [OPERAND_W-1:0] alu_x;
   logic [OPERAND_W-1:0] alu_y;
   logic [OPERAND_W-1:0] alu_a_divide;
   alu_op_e              alu_op;
   logic                 alu_begin;
   logic                 alu_end;
   logic [RESULT_W-1:0]  alu_out;
   logic                 alu_flush;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [RESULT_W-1:0]  rsp_data;
   alu_op_e              rsp_op;
   logic                 rsp_timeout;
   logic                 busy;
   logic [COUNT_W-1:0]   done_count;

   modport master (
      input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_a_hi,
      input  alu_end, alu_out, rsp_ready,
      output cmd_ready, alu_x, alu_y, alu_a_divide, alu_op, alu_begin, alu_flush,
      output rsp_valid, rsp_data, rsp_op, rsp_timeout, busy, done_count
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_a_hi,
      output alu_end, alu_out, rsp_ready,
      input  cmd_ready, alu_x, alu_y, alu_a_divide, alu_op, alu_begin, alu_flush,
      input  rsp_valid, rsp_data, rsp_op, rsp_timeout, busy, done_count
   );

endinterface

// File: rtl/alu_watchdog.sv
// WAIT-state cycle counter for alu_cmd_driver; only exists when ALU_TIMEOUT_EN is defined.
`ifdef ALU_TIMEOUT_EN
module alu_watchdog
   import alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_expired
);

   logic [WDOG_W-1:0] r_count;

   // Held at zero outside WAIT, so every WAIT visit starts counting from 0.
   always_ff @(posedge clk) begin
      if (reset || !i_en) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + WDOG_W'(1);
      end
   end

   assign o_expired = i_en && (r_count == WDOG_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/alu_cmd_driver.sv
// Initiator for the ALU BEGIN/END handshake: one command in, one registered result out.
// Optional WAIT timeout with ALU flush is enabled by defining ALU_TIMEOUT_EN.
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int BEGIN_PULSE = 1
`ifdef ALU_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic           clk,
   input  logic           reset,
   alu_cmd_driver_if.master bus
);

   state_e               r_state;
   state_e               w_state_next;
   logic [15:0]          r_pulse_cnt;
   logic [15:0]          w_pulse_cnt_next;

   logic                 r_cmd_ready;
   logic [OPERAND_W-1:0] r_alu_x;
   logic [OPERAND_W-1:0] r_alu_y;
   logic [OPERAND_W-1:0] r_alu_a;
   alu_op_e              r_alu_op;
   logic                 r_alu_begin;
   logic                 r_alu_flush;
   logic                 r_rsp_valid;
   logic [RESULT_W-1:0]  r_rsp_data;
   alu_op_e              r_rsp_op;
   logic                 r_rsp_timeout;
   logic                 r_busy;
   logic [COUNT_W-1:0]   r_done_count;

   logic                 w_accept;
   logic                 w_capture;
   logic                 w_expire;
   logic                 w_rsp_done;
   logic                 w_timeout;

`ifdef ALU_TIMEOUT_EN
   alu_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .i_en      (r_state == ST_WAIT),
      .o_expired (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_next     = r_state;
      w_pulse_cnt_next = r_pulse_cnt;
      w_accept         = 1'b0;
      w_capture        = 1'b0;
      w_expire         = 1'b0;
      w_rsp_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.cmd_valid && r_cmd_ready) begin
               w_accept     = 1'b1;
               w_state_next = ST_ARM;
            end
         end
         // A still-high END belongs to the previous operation; wait it out.
         ST_ARM: begin
            if (!bus.alu_end) begin
               w_state_next     = ST_BEGIN;
               w_pulse_cnt_next = '0;
            end
         end
         ST_BEGIN: begin
            if (r_pulse_cnt == 16'(BEGIN_PULSE - 1)) begin
               w_state_next = ST_WAIT;
            end else begin
               w_pulse_cnt_next = r_pulse_cnt + 16'd1;
            end
         end
         ST_WAIT: begin
            if (bus.alu_end) begin
               w_capture    = 1'b1;
               w_state_next = ST_RESP;
            end else if (w_timeout) begin
               w_expire     = 1'b1;
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               w_rsp_done   = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_pulse_cnt   <= '0;
         r_cmd_ready   <= 1'b1;
         r_alu_x       <= '0;
         r_alu_y       <= '0;
         r_alu_a       <= '0;
         r_alu_op      <= OP_ADD;
         r_alu_begin   <= 1'b0;
         r_alu_flush   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_op      <= OP_ADD;
         r_rsp_timeout <= 1'b0;
         r_busy        <= 1'b0;
         r_done_count  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_pulse_cnt <= w_pulse_cnt_next;
         // Status outputs follow the next state so they line up with it.
         r_cmd_ready <= (w_state_next == ST_IDLE);
         r_busy      <= (w_state_next != ST_IDLE);
         r_alu_begin <= (w_state_next == ST_BEGIN);
         r_alu_flush <= w_expire;
         if (w_accept) begin
            r_alu_x  <= bus.cmd_x;
            r_alu_y  <= bus.cmd_y;
            r_alu_a  <= bus.cmd_a_hi;
            r_alu_op <= bus.cmd_op;
         end
         if (w_capture) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= bus.alu_out;
            r_rsp_op      <= r_alu_op;
            r_rsp_timeout <= 1'b0;
            r_done_count  <= r_done_count + COUNT_W'(1);
         end else if (w_expire) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_op      <= r_alu_op;
            r_rsp_timeout <= 1'b1;
         end else if (w_rsp_done) begin
            r_rsp_valid   <= 1'b0;
         end
      end
   end

   assign bus.cmd_ready    = r_cmd_ready;
   assign bus.alu_x        = r_alu_x;
   assign bus.alu_y        = r_alu_y;
   assign bus.alu_a_divide = r_alu_a;
   assign bus.alu_op       = r_alu_op;
   assign bus.alu_begin    = r_alu_begin;
   assign bus.alu_flush    = r_alu_flush;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_data     = r_rsp_data;
   assign bus.rsp_op       = r_rsp_op;
   assign bus.rsp_timeout  = r_rsp_timeout;
   assign bus.busy         = r_busy;
   assign bus.done_count   = r_done_count;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed + randomized bench for alu_cmd_driver with a behavioural ALU and result reference.
// Build with ALU_TIMEOUT_EN defined to exercise the timeout path.
module tb_alu_cmd_driver;
   import alu_pkg::*;

   localparam int BP = 1;
`ifdef ALU_TIMEOUT_EN
   localparam int TO = 64;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   alu_cmd_driver_if bus ();

   alu_cmd_driver #(
      .BEGIN_PULSE (BP)
`ifdef ALU_TIMEOUT_EN
      , .TIMEOUT_CYCLES (TO)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural ALU: what the result of an operation must be.
   function automatic logic [15:0] alu_ref(input alu_op_e op, input logic [7:0] x,
                                           input logic [7:0] y, input logic [7:0] a);
      logic [15:0] dividend;
      dividend = {a, x};
      case (op)
         OP_ADD:  return 16'(x) + 16'(y);
         OP_SUB:  return 16'(x) - 16'(y);
         OP_MUL:  return 16'(x) * 16'(y);
         default: return (y == 8'd0) ? 16'hFFFF : dividend / 16'(y);
      endcase
   endfunction

   // ALU model: END one cycle, end_delay cycles after BEGIN rises; or manual drive.
   bit          model_en  = 1'b1;
   int          end_delay = 10;
   logic        man_end   = 1'b0;
   logic [15:0] man_out   = 16'h0;
   int          m_cnt     = 0;
   logic        beg_prev  = 1'b0;
   logic        m_end     = 1'b0;
   logic [15:0] m_out     = 16'h0;
   logic        end_q     = 1'b0;

   always @(negedge clk) begin
      if (model_en) begin
         m_end = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_end = 1'b1;
               m_out = alu_ref(bus.alu_op, bus.alu_x, bus.alu_y, bus.alu_a_divide);
            end
         end
         if (bus.alu_begin && !beg_prev) m_cnt = end_delay;
         beg_prev    = bus.alu_begin;
         bus.alu_end = m_end;
         bus.alu_out = m_out;
      end else begin
         m_cnt       = 0;
         beg_prev    = bus.alu_begin;
         bus.alu_end = man_end;
         bus.alu_out = man_out;
      end
   end

   always @(posedge clk) end_q <= bus.alu_end;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input alu_op_e op, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] a);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_x     = x;
      bus.cmd_y     = y;
      bus.cmd_a_hi  = a;
      tick();
      bus.cmd_valid = 1'b0;
      check("latch_x", bus.alu_x, x);
      check("latch_y", bus.alu_y, y);
      check("latch_a", bus.alu_a_divide, a);
      check("latch_op", bus.alu_op, op);
      check("accept_cmd_ready", bus.cmd_ready, 1'b0);
      check("accept_busy", bus.busy, 1'b1);
      $display("cmd op=%0d x=%02h y=%02h a=%02h accepted at %0t", op, x, y, a, $time);
   endtask

   task automatic wait_rsp(input int limit, input bit expect_end);
      int cyc;
      cyc = 0;
      while (!bus.rsp_valid && cyc < limit) begin
         tick();
         cyc++;
      end
      check("rsp_arrives", bus.rsp_valid, 1'b1);
      if (expect_end) check("rsp_after_end", end_q, 1'b1);
   endtask

   task automatic take_rsp();
      $display("rsp data=%04h op=%0d timeout=%0d done=%0d at %0t",
               bus.rsp_data, bus.rsp_op, bus.rsp_timeout, bus.done_count, $time);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("rsp_drop", bus.rsp_valid, 1'b0);
      check("idle_cmd_ready", bus.cmd_ready, 1'b1);
   endtask

   initial begin
      int          exp_done;
      alu_op_e     op;
      logic [7:0]  x, y, a;
      logic [15:0] exp_data;
      bit          seen;
      int          hold;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_ADD;
      bus.cmd_x     = 8'h0;
      bus.cmd_y     = 8'h0;
      bus.cmd_a_hi  = 8'h0;
      bus.rsp_ready = 1'b0;
      exp_done      = 0;

      // Reset state
      repeat (3) tick();
      check("rst_cmd_ready", bus.cmd_ready, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_begin", bus.alu_begin, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_data", bus.rsp_data, 16'h0);
      check("rst_done", bus.done_count, 8'h0);
      check("rst_alu_x", bus.alu_x, 8'h0);
      check("rst_flush", bus.alu_flush, 1'b0);
      check("rst_timeout", bus.rsp_timeout, 1'b0);
      reset = 1'b0;
      tick();

      // MUL 7*6, END 10 cycles after BEGIN
      send_cmd(OP_MUL, 8'd7, 8'd6, 8'h55);
      check("begin_before", bus.alu_begin, 1'b0);
      tick();
      check("begin_pulse", bus.alu_begin, 1'b1);
      tick();
      check("begin_one_cycle", bus.alu_begin, 1'b0);
      wait_rsp(100, 1'b1);
      exp_done++;
      check("mul_data", bus.rsp_data, 16'h002A);
      check("mul_op", bus.rsp_op, OP_MUL);
      check("mul_done", bus.done_count, 8'(exp_done));
      check("mul_timeout", bus.rsp_timeout, 1'b0);

      // Response back-pressure with a second command pending
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_ADD;
      bus.cmd_x     = 8'h11;
      bus.cmd_y     = 8'h22;
      bus.cmd_a_hi  = 8'h00;
      repeat (5) begin
         tick();
         check("hold_valid", bus.rsp_valid, 1'b1);
         check("hold_data", bus.rsp_data, 16'h002A);
         check("hold_cmd_ready", bus.cmd_ready, 1'b0);
         check("hold_no_accept", bus.alu_x, 8'd7);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("hs_rsp_drop", bus.rsp_valid, 1'b0);
      check("hs_no_accept", bus.alu_x, 8'd7);
      check("hs_cmd_ready", bus.cmd_ready, 1'b1);
      tick();
      bus.cmd_valid = 1'b0;
      check("second_accept", bus.alu_x, 8'h11);
      check("second_busy", bus.busy, 1'b1);
      wait_rsp(100, 1'b1);
      exp_done++;
      check("add_data", bus.rsp_data, alu_ref(OP_ADD, 8'h11, 8'h22, 8'h00));
      check("add_done", bus.done_count, 8'(exp_done));
      take_rsp();

      // Randomized operations against the reference
      for (int i = 0; i < 10; i++) begin
         op        = alu_op_e'($urandom_range(0, 3));
         x         = 8'($urandom);
         y         = 8'($urandom);
         a         = 8'($urandom);
         end_delay = $urandom_range(1, 8);
         exp_data  = alu_ref(op, x, y, a);
         send_cmd(op, x, y, a);
         wait_rsp(100, 1'b1);
         exp_done++;
         check("rnd_data", bus.rsp_data, exp_data);
         check("rnd_op", bus.rsp_op, op);
         check("rnd_done", bus.done_count, 8'(exp_done));
         hold = $urandom_range(0, 3);
         for (int k = 0; k < hold; k++) begin
            tick();
            check("rnd_hold_data", bus.rsp_data, exp_data);
         end
         take_rsp();
      end

      // Stale END high at accept withholds BEGIN
      model_en = 1'b0;
      man_end  = 1'b1;
      tick();
      send_cmd(OP_SUB, 8'h10, 8'h30, 8'h00);
      repeat (4) begin
         tick();
         check("stale_no_begin", bus.alu_begin, 1'b0);
         check("stale_busy", bus.busy, 1'b1);
      end
      man_end = 1'b0;
      tick();
      check("stale_begin", bus.alu_begin, 1'b1);
      tick();
      check("stale_begin_drop", bus.alu_begin, 1'b0);
      man_out = alu_ref(OP_SUB, 8'h10, 8'h30, 8'h00);
      man_end = 1'b1;
      tick();
      man_end = 1'b0;
      wait_rsp(10, 1'b1);
      exp_done++;
      check("sub_data", bus.rsp_data, 16'hFFE0);
      check("sub_done", bus.done_count, 8'(exp_done));
      take_rsp();

`ifdef ALU_TIMEOUT_EN
      // END never arrives: timeout after TO WAIT cycles
      send_cmd(OP_DIV, 8'h34, 8'h12, 8'h01);
      tick();
      check("to_begin", bus.alu_begin, 1'b1);
      hold = 0;
      while (!bus.rsp_valid && hold < 200) begin
         tick();
         hold++;
      end
      check("to_latency", 32'(hold), 32'(TO + BP));
      check("to_valid", bus.rsp_valid, 1'b1);
      check("to_flag", bus.rsp_timeout, 1'b1);
      check("to_data", bus.rsp_data, 16'h0);
      check("to_flush", bus.alu_flush, 1'b1);
      check("to_op", bus.rsp_op, OP_DIV);
      check("to_done", bus.done_count, 8'(exp_done));
      tick();
      check("to_flush_drop", bus.alu_flush, 1'b0);
      man_end = 1'b1;
      tick();
      man_end = 1'b0;
      tick();
      check("late_end_done", bus.done_count, 8'(exp_done));
      check("late_end_flag", bus.rsp_timeout, 1'b1);
      check("late_end_data", bus.rsp_data, 16'h0);
      take_rsp();
      send_cmd(OP_MUL, 8'h02, 8'h03, 8'h00);
      repeat (5) tick();
`else
      // END never arrives and there is no timeout: no response at all
      send_cmd(OP_DIV, 8'h34, 8'h12, 8'h01);
      seen = 1'b0;
      repeat (1000) begin
         tick();
         if (bus.rsp_valid) seen = 1'b1;
      end
      check("no_rsp_unbounded", seen, 1'b0);
      check("no_timeout_flag", bus.rsp_timeout, 1'b0);
      check("no_flush", bus.alu_flush, 1'b0);
`endif

      // Reset during WAIT, then a stray END
      check("wait_busy", bus.busy, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_begin", bus.alu_begin, 1'b0);
      check("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
      check("mid_rst_valid", bus.rsp_valid, 1'b0);
      check("mid_rst_done", bus.done_count, 8'h0);
      exp_done = 0;
      man_end  = 1'b1;
      tick();
      man_end  = 1'b0;
      seen     = 1'b0;
      repeat (4) begin
         tick();
         if (bus.rsp_valid || bus.busy) seen = 1'b1;
      end
      check("stray_end_ignored", seen, 1'b0);

      // Recovery after reset
      model_en  = 1'b1;
      end_delay = 3;
      send_cmd(OP_ADD, 8'hFF, 8'h01, 8'h00);
      wait_rsp(100, 1'b1);
      exp_done++;
      check("recover_data", bus.rsp_data, 16'h0100);
      check("recover_done", bus.done_count, 8'(exp_done));
      take_rsp();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
